// File: rtl/vedic3_mac_accum.sv
// Two-stage multiply-accumulate around a 3x3 vedic multiplier.
// Define VEDIC3_MAC_SAT_EN to clamp the frame sum instead of wrapping.

module vedic3bit (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] p
);

    logic [1:0] t1;
    logic [2:0] t2;
    logic [2:0] t3;
    logic [1:0] t4;

    // Vertical-and-crosswise columns, each carrying into the next.
    always_comb begin
        t1 = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
        t2 = {2'b0, a[2] & b[0]} + {2'b0, a[1] & b[1]}
           + {2'b0, a[0] & b[2]} + {2'b0, t1[1]};
        t3 = {2'b0, a[2] & b[1]} + {2'b0, a[1] & b[2]}
           + {1'b0, t2[2:1]};
        t4 = {1'b0, a[2] & b[2]} + t3[2:1];
        p  = {t4, t3[0], t2[0], t1[0], a[0] & b[0]};
    end

endmodule

module vedic3_mac_accum #(
    parameter int ACC_W     = 8,
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_a,
    input  logic [2:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_terms,
    output logic             out_ovf
);

    localparam logic [CNT_W:0] MAX_C = MAX_TERMS[CNT_W:0];

    logic [5:0]       prod;
    logic             accept;
    logic             in_close;
    logic [CNT_W:0]   in_cnt_inc;

    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_close_q, s1_close_d;
    logic [ACC_W-1:0] s1_prod_q, s1_prod_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_terms_q, out_terms_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum_w;
    logic             ovf_now;
    logic [ACC_W-1:0] acc_next;

    vedic3bit u_mul (
        .a (in_a),
        .b (in_b),
        .p (prod)
    );

    assign in_ready = !out_valid_q && !(s1_valid_q && s1_close_q);
    assign accept   = in_valid && in_ready;

    // The input side keeps its own beat count so a forced close is
    // known at accept time, ahead of the lagging stage-2 counter.
    assign in_cnt_inc = {1'b0, in_cnt_q} + (CNT_W + 1)'(1);
    assign in_close   = in_last || (in_cnt_inc == MAX_C);

    always_comb begin
        in_cnt_d   = in_cnt_q;
        s1_valid_d = accept;
        s1_close_d = 1'b0;
        s1_prod_d  = s1_prod_q;
        if (accept) begin
            in_cnt_d   = in_close ? '0 : in_cnt_inc[CNT_W-1:0];
            s1_close_d = in_close;
            s1_prod_d  = ACC_W'(prod);
        end
    end

    always_comb begin
        acc_base = (term_cnt_q == '0) ? '0 : acc_q;
        sum_w    = {1'b0, acc_base} + {1'b0, s1_prod_q};
        ovf_now  = ovf_q || sum_w[ACC_W];
`ifdef VEDIC3_MAC_SAT_EN
        acc_next = ovf_now ? '1 : sum_w[ACC_W-1:0];
`else
        acc_next = sum_w[ACC_W-1:0];
`endif
    end

    always_comb begin
        acc_d       = acc_q;
        term_cnt_d  = term_cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_terms_d = out_terms_q;
        out_ovf_d   = out_ovf_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (s1_valid_q) begin
            if (s1_close_q) begin
                out_sum_d   = acc_next;
                out_terms_d = term_cnt_q + CNT_W'(1);
                out_ovf_d   = ovf_now;
                out_valid_d = 1'b1;
                acc_d       = '0;
                term_cnt_d  = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d      = acc_next;
                term_cnt_d = term_cnt_q + CNT_W'(1);
                ovf_d      = ovf_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_close_q  <= 1'b0;
            s1_prod_q   <= '0;
            acc_q       <= '0;
            term_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_terms_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_close_q  <= s1_close_d;
            s1_prod_q   <= s1_prod_d;
            acc_q       <= acc_d;
            term_cnt_q  <= term_cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_terms_q <= out_terms_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_terms = out_terms_q;
    assign out_ovf   = out_ovf_q;

endmodule
